sha256_compression_core: RTL and testbench

Consumer side of the SHA-256 message-schedule interface. Accepts one 512-bit block request and drives the scheduler's init strobe. Consumes one 32-bit schedule word Wt per cycle for 64 rounds, then adds the working variables into the chaining state and presents the 256-bit intermediate/final hash. Supports multi-block messages by chaining H across blocks, or restarting from the standard IV.

---
 rtl/sha256_compression_core.sv | 141 ++++++++++++++
 tb/tb_sha256_compression_core.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_compression_core.sv
// SHA-256 compression core: consumer side of the message-schedule interface.
// Accepts one 512-bit block request, strobes the scheduler, runs 64 rounds on
// the incoming Wt stream, folds the working variables into H and presents the
// digest. Multi-block messages chain H; first_i restarts from the IV.
//
// Ports:
//   clk_i         clock, all state updates on the rising edge
//   reset_i       synchronous active-high reset
//   v_i/first_i   block request / first-block-of-message flag (sampled on accept)
//   ready_o       core can accept a block this cycle
//   sched_init_o  scheduler init strobe (combinational: v_i & ready_o)
//   Wt_i          schedule word W[t], valid during round t
//   round_o       current round index (0 outside the round phase)
//   v_o           one-cycle pulse, digest_o refreshed for the finished block
//   digest_o      {H0..H7}, H0 in [255:224]
module sha256_compression_core (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         v_i,
  input  logic         first_i,
  output logic         ready_o,
  output logic         sched_init_o,
  input  logic [31:0]  Wt_i,
  output logic [5:0]   round_o,
  output logic         v_o,
  output logic [255:0] digest_o
);

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned NUM_WORDS = 8;
  localparam int unsigned ROUNDS    = 64;
  localparam int unsigned ROUND_W   = 6;
  localparam int unsigned DIGEST_W  = WORD_W * NUM_WORDS;

  localparam logic [WORD_W-1:0] IV [NUM_WORDS] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [WORD_W-1:0] K [ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   h_q  [NUM_WORDS];  // chaining state H0..H7
  logic [WORD_W-1:0]   wv_q [NUM_WORDS];  // working variables a..h at index 0..7
  logic [ROUND_W-1:0]  t_q;
  logic                accept;
  logic [WORD_W-1:0]   s0_c, s1_c, ch_c, maj_c, t1_c, t2_c;

  // State register
  always_ff @(posedge clk_i) begin : state_reg
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next state, handshake and completion decode
  always_comb begin : fsm_comb
    state_d = state_q;
    ready_o = 1'b0;
    v_o     = 1'b0;
    accept  = 1'b0;
    case (state_q)
      S_IDLE:  ready_o = 1'b1;
      S_ROUND: if (t_q == ROUND_W'(ROUNDS - 1)) state_d = S_FINAL;
      S_FINAL: state_d = S_DONE;
      S_DONE: begin
        ready_o = 1'b1;
        v_o     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // An accept in DONE starts the next block exactly as from IDLE.
    accept = v_i & ready_o & ~reset_i;
    if (accept) state_d = S_ROUND;
  end

  assign sched_init_o = accept;
  assign round_o      = t_q;

  // Round functions on the current working variables
  assign s0_c  = {wv_q[0][1:0],  wv_q[0][31:2]}  ^ {wv_q[0][12:0], wv_q[0][31:13]} ^
                 {wv_q[0][21:0], wv_q[0][31:22]};
  assign s1_c  = {wv_q[4][5:0],  wv_q[4][31:6]}  ^ {wv_q[4][10:0], wv_q[4][31:11]} ^
                 {wv_q[4][24:0], wv_q[4][31:25]};
  assign ch_c  = (wv_q[4] & wv_q[5]) ^ (~wv_q[4] & wv_q[6]);
  assign maj_c = (wv_q[0] & wv_q[1]) ^ (wv_q[0] & wv_q[2]) ^ (wv_q[1] & wv_q[2]);
  assign t1_c  = wv_q[7] + s1_c + ch_c + K[t_q] + Wt_i;
  assign t2_c  = s0_c + maj_c;

  // Working variables, chaining state, round counter and digest register
  always_ff @(posedge clk_i) begin : datapath
    if (reset_i) begin
      h_q      <= IV;
      for (int i = 0; i < int'(NUM_WORDS); i++) wv_q[i] <= '0;
      t_q      <= '0;
      digest_o <= '0;
    end else if (accept) begin
      t_q <= '0;
      if (first_i) begin
        h_q  <= IV;
        wv_q <= IV;
      end else begin
        wv_q <= h_q;
      end
    end else begin
      case (state_q)
        S_ROUND: begin
          wv_q[7] <= wv_q[6];
          wv_q[6] <= wv_q[5];
          wv_q[5] <= wv_q[4];
          wv_q[4] <= wv_q[3] + t1_c;
          wv_q[3] <= wv_q[2];
          wv_q[2] <= wv_q[1];
          wv_q[1] <= wv_q[0];
          wv_q[0] <= t1_c + t2_c;
          // Wraps to 0 after the last round so round_o reads 0 outside ROUND.
          t_q     <= t_q + ROUND_W'(1);
        end
        S_FINAL: begin
          for (int i = 0; i < int'(NUM_WORDS); i++) begin
            h_q[i] <= h_q[i] + wv_q[i];
            digest_o[DIGEST_W - 1 - WORD_W * i -: WORD_W] <= h_q[i] + wv_q[i];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_compression_core.sv
// Bench for sha256_compression_core, paired with a behavioural message scheduler.
module tb_sha256_compression_core;

  localparam logic [511:0] ABC_MSG   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] EMPTY_MSG = {32'h80000000, {15{32'h0}}};
  localparam logic [511:0] TWO_MSG1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_MSG2  = {{15{32'h0}}, 32'h000001c0};
  localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_DIG   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         v_i;
  logic         first_i;
  logic         ready_o;
  logic         sched_init_o;
  logic [31:0]  Wt_i;
  logic [5:0]   round_o;
  logic         v_o;
  logic [255:0] digest_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [255:0] sb_q [$];

  always #5 clk_i = ~clk_i;

  sha256_compression_core dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .v_i          (v_i),
    .first_i      (first_i),
    .ready_o      (ready_o),
    .sched_init_o (sched_init_o),
    .Wt_i         (Wt_i),
    .round_o      (round_o),
    .v_o          (v_o),
    .digest_o     (digest_o)
  );

  // Message scheduler: expands M on sched_init_o, streams W[t] from the next cycle
  logic [511:0] msg_r;
  logic [31:0]  w_tab [64];
  logic [5:0]   tb_t = 6'd0;

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  always @(posedge clk_i) begin : sched
    logic [31:0] w [64];
    if (sched_init_o) begin
      for (int i = 0; i < 16; i++) w[i] = msg_r[511 - 32 * i -: 32];
      for (int i = 16; i < 64; i++) w[i] = ssig1(w[i-2]) + w[i-7] + ssig0(w[i-15]) + w[i-16];
      w_tab <= w;
      tb_t  <= 6'd0;
    end else begin
      tb_t  <= tb_t + 6'd1;
    end
  end

  assign Wt_i = w_tab[tb_t];

  // Drives one request from a negedge; returns at the negedge of cycle A+1
  task automatic issue(input logic [511:0] m, input logic f, input bit push, input logic [255:0] exp);
    msg_r   = m;
    first_i = f;
    v_i     = 1'b1;
    #1;
    if (push && sched_init_o) sb_q.push_back(exp);
    @(posedge clk_i);
    @(negedge clk_i);
    v_i = 1'b0;
  endtask

  // Counts cycles since accept until v_o; lat is 1 at entry
  task automatic wait_vo(output int lat, output bit timeout);
    lat = 1;
    timeout = 1'b0;
    while (!v_o) begin
      if (lat >= 200) begin
        timeout = 1'b1;
        break;
      end
      @(negedge clk_i);
      lat++;
    end
  endtask

  task automatic test_reset;
    reset_i = 1'b1; v_i = 1'b1; first_i = 1'b0; msg_r = '0;
    repeat (3) @(negedge clk_i);
    #1;
    n_checks++; if (ready_o !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready_o); else n_pass++;
    n_checks++; if (v_o !== 1'b0) $display("FAIL reset_v_o: got %b expected 0", v_o); else n_pass++;
    n_checks++; if (sched_init_o !== 1'b0) $display("FAIL reset_sched_init: got %b expected 0", sched_init_o); else n_pass++;
    n_checks++; if (round_o !== 6'd0) $display("FAIL reset_round: got %0d expected 0", round_o); else n_pass++;
    n_checks++; if (digest_o !== 256'd0) $display("FAIL reset_digest: got %h expected 0", digest_o); else n_pass++;
    v_i = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_abc;
    int lat; bit to; logic [255:0] exp;
    issue(ABC_MSG, 1'b1, 1'b1, ABC_DIG);
    wait_vo(lat, to);
    n_checks++; if (to || lat != 66) $display("FAIL abc_latency: got %0d expected 66", lat); else n_pass++;
    n_checks++;
    if (sb_q.size() == 0) $display("FAIL abc_digest: got %h with nothing expected queued", digest_o);
    else begin
      exp = sb_q.pop_front();
      if (digest_o !== exp) $display("FAIL abc_digest: got %h expected %h", digest_o, exp); else n_pass++;
    end
    @(negedge clk_i);
    n_checks++; if (v_o !== 1'b0 || ready_o !== 1'b1) $display("FAIL abc_vo_pulse: v_o=%b ready=%b expected 0/1", v_o, ready_o); else n_pass++;
  endtask

  task automatic test_empty;
    int lat; bit to; logic [255:0] exp;
    issue(EMPTY_MSG, 1'b1, 1'b1, EMPTY_DIG);
    wait_vo(lat, to);
    n_checks++; if (to || lat != 66) $display("FAIL empty_latency: got %0d expected 66", lat); else n_pass++;
    n_checks++;
    if (sb_q.size() == 0) $display("FAIL empty_digest: got %h with nothing expected queued", digest_o);
    else begin
      exp = sb_q.pop_front();
      if (digest_o !== exp) $display("FAIL empty_digest: got %h expected %h", digest_o, exp); else n_pass++;
    end
    @(negedge clk_i);
  endtask

  task automatic test_two_block;
    int lat; bit to; logic [255:0] exp;
    issue(TWO_MSG1, 1'b1, 1'b0, '0);
    wait_vo(lat, to);
    n_checks++; if (to || lat != 66) $display("FAIL two_blk1_latency: got %0d expected 66", lat); else n_pass++;
    // Second block accepted in the DONE cycle of the first
    issue(TWO_MSG2, 1'b0, 1'b1, TWO_DIG);
    wait_vo(lat, to);
    n_checks++; if (to || lat != 66) $display("FAIL two_blk2_latency: got %0d expected 66", lat); else n_pass++;
    n_checks++;
    if (sb_q.size() == 0) $display("FAIL two_digest: got %h with nothing expected queued", digest_o);
    else begin
      exp = sb_q.pop_front();
      if (digest_o !== exp) $display("FAIL two_digest: got %h expected %h", digest_o, exp); else n_pass++;
    end
    @(negedge clk_i);
  endtask

  task automatic test_back_to_back;
    int pulses = 0; int lows = 0; int vcnt = 0; int vo_c0 = -1; int vo_c1 = -1;
    logic [255:0] exp;
    msg_r = ABC_MSG; first_i = 1'b1; v_i = 1'b1;
    for (int c = 0; c <= 200 && vcnt < 2; c++) begin
      if (c == 30) first_i = 1'b0;
      if (c == 60) first_i = 1'b1;
      if (c == 67) v_i = 1'b0;
      if (c == 96) first_i = 1'b0;
      #1;
      if (sched_init_o) begin pulses++; sb_q.push_back(ABC_DIG); end
      if (!ready_o) lows++;
      if (v_o) begin
        if (vcnt == 0) vo_c0 = c; else vo_c1 = c;
        vcnt++;
        n_checks++;
        if (sb_q.size() == 0) $display("FAIL hold_digest%0d: got %h with nothing expected queued", vcnt, digest_o);
        else begin
          exp = sb_q.pop_front();
          if (digest_o !== exp) $display("FAIL hold_digest%0d: got %h expected %h", vcnt, digest_o, exp); else n_pass++;
        end
      end
      @(negedge clk_i);
    end
    first_i = 1'b1;
    n_checks++; if (pulses != 2) $display("FAIL hold_sched_pulses: got %0d expected 2", pulses); else n_pass++;
    n_checks++; if (lows != 130) $display("FAIL hold_ready_low: got %0d expected 130", lows); else n_pass++;
    n_checks++; if (vo_c0 != 66 || vo_c1 != 132) $display("FAIL hold_vo_cycles: got %0d,%0d expected 66,132", vo_c0, vo_c1); else n_pass++;
  endtask

  task automatic test_reset_abort;
    int lat; bit to; bit found = 1'b0; bit saw_v = 1'b0; logic [255:0] exp;
    issue(ABC_MSG, 1'b1, 1'b0, '0);
    for (int c = 0; c < 100; c++) begin
      if (round_o == 6'd30) begin found = 1'b1; break; end
      @(negedge clk_i);
    end
    n_checks++; if (!found) $display("FAIL abort_reach_round30: got round %0d expected 30", round_o); else n_pass++;
    reset_i = 1'b1;
    @(negedge clk_i);
    n_checks++; if (ready_o !== 1'b1) $display("FAIL abort_ready: got %b expected 1", ready_o); else n_pass++;
    n_checks++; if (digest_o !== 256'd0) $display("FAIL abort_digest: got %h expected 0", digest_o); else n_pass++;
    n_checks++; if (v_o !== 1'b0 || round_o !== 6'd0) $display("FAIL abort_idle: v_o=%b round=%0d expected 0/0", v_o, round_o); else n_pass++;
    reset_i = 1'b0;
    repeat (80) begin
      @(negedge clk_i);
      if (v_o) saw_v = 1'b1;
    end
    n_checks++; if (saw_v) $display("FAIL abort_no_vo: got v_o pulse expected none"); else n_pass++;
    issue(ABC_MSG, 1'b1, 1'b1, ABC_DIG);
    wait_vo(lat, to);
    n_checks++; if (to || lat != 66) $display("FAIL abort_retry_latency: got %0d expected 66", lat); else n_pass++;
    n_checks++;
    if (sb_q.size() == 0) $display("FAIL abort_retry_digest: got %h with nothing expected queued", digest_o);
    else begin
      exp = sb_q.pop_front();
      if (digest_o !== exp) $display("FAIL abort_retry_digest: got %h expected %h", digest_o, exp); else n_pass++;
    end
    @(negedge clk_i);
  endtask

  task automatic test_iv_restart;
    int lat; bit to; logic [255:0] exp;
    for (int k = 0; k < 2; k++) begin
      issue(ABC_MSG, 1'b1, 1'b1, ABC_DIG);
      wait_vo(lat, to);
      n_checks++;
      if (to || sb_q.size() == 0) $display("FAIL iv_restart%0d: got timeout/empty queue (lat %0d) expected digest", k, lat);
      else begin
        exp = sb_q.pop_front();
        if (digest_o !== exp) $display("FAIL iv_restart%0d: got %h expected %h", k, digest_o, exp); else n_pass++;
      end
      @(negedge clk_i);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1; v_i = 1'b0; first_i = 1'b0; msg_r = '0;
    @(negedge clk_i);
    test_reset;
    test_abc;
    test_empty;
    test_two_block;
    test_back_to_back;
    test_reset_abort;
    test_iv_restart;
    n_checks++; if (sb_q.size() != 0) $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
